hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and fetch-redirect controller for the 5-stage RISC-V core. It drives the fetch PC register's `start`, `stallF`, `flushF` and `pc_restore` inputs, plus the stall/flush controls of the IF/ID and ID/EX registers. It resolves three hazards:
- the post-reset boot hold;
- data-memory wait stalls;
- EX-stage branch/jump redirects and load-use hazards.

A redirect that arrives during a memory stall is held pending.

## Interface
Parameters:
- `BOOT_CYCLES`, default 4: number of cycles `start` is held high after reset release; legal range 1..255.
- `XLEN`, default 32: PC / target width.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction actually reads rs1 / rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_redirect`  in  1  EX resolved a taken branch or jump.
- `ex_target`  in  XLEN  redirect target PC.
- `mem_busy`  in  1  data memory not ready; whole pipe must hold.
- `start`  out  1  hold PC during boot.
- `stallF`, `stallD`, `stallE`  out  1 each  hold the PC, IF/ID and ID/EX registers.
- `flushF`  out  1  load `pc_restore` into the PC.
- `flushD`, `flushE`  out  1 each  bubble the IF/ID and ID/EX registers.
- `pc_restore`  out  XLEN  redirect PC.
- `stall_cnt`, `flush_cnt`  out  32 each  performance counters (see Configuration).

## Operation
States: BOOT, RUN, PEND.

BOOT
- Entered on `rst`.
- A down-counter is loaded with `BOOT_CYCLES-1`.
- Outputs: `start`=1, `flushD`=1, `flushE`=1; all other controls 0.
- Leaves to RUN on the cycle after the counter reads 0.

RUN, priority highest first:
1. `mem_busy` and `ex_redirect` both high:
   - Capture `ex_target` into `pend_target`; go to PEND.
   - Outputs: `stallF`=`stallD`=`stallE`=1; no flushes.
2. `mem_busy` only: `stallF`=`stallD`=`stallE`=1; no flushes.
3. `ex_redirect`: `flushF`=`flushD`=`flushE`=1, `pc_restore`=`ex_target`.
4. Load-use, detected when `ex_mem_read` and `ex_rd`≠0 and ((`id_use_rs1` and `id_rs1`==`ex_rd`) or (`id_use_rs2` and `id_rs2`==`ex_rd`)):
   - Outputs: `stallF`=`stallD`=1, `flushE`=1, for exactly one cycle.
5. Otherwise all controls 0.

PEND
- While `mem_busy`: `stallF`=`stallD`=`stallE`=1.
- First cycle `mem_busy`=0:
  - Outputs: `flushF`=`flushD`=`flushE`=1, `pc_restore`=`pend_target`.
  - `ex_redirect`/`ex_target` are ignored that cycle.
  - Return to RUN.

General rules:
- `pc_restore` = `pend_target` in PEND, else `ex_target`. It is meaningful only when `flushF`=1.
- `start`, the state and `pend_target` are registered. All other controls are combinational from the current state and inputs.
- `flushF` and `stallF` are never both 1.

## Timing
Reset values (state BOOT):
- `start`=1, `flushD`=1, `flushE`=1.
- `stallF`, `stallD`, `stallE`, `flushF` = 0.
- `pend_target`=0, `pc_restore`=`ex_target`, counters 0.

Cycle behaviour:
- After `rst` falls, `start` stays high for exactly `BOOT_CYCLES` rising edges.
- Redirect latency: 0 cycles. `flushF` is asserted in the same cycle as `ex_redirect`, so the PC holds the target after the next edge.
- A redirect arriving during a stall is applied in the first non-busy cycle.
- Load-use bubble: 1 cycle. On the next cycle the load has left EX and the stall clears.
- `rst` asserted mid-PEND: the pending redirect is discarded and the controller returns to BOOT asynchronously.
- Inputs during BOOT are ignored.

## Configuration
Macro: `HAZARD_PERF_CNT_EN`.
- Defined:
  - `stall_cnt` increments on each RUN/PEND cycle with `stallF`=1.
  - `flush_cnt` increments on each cycle with `flushF`=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Boot: release `rst` with `BOOT_CYCLES`=4 → `start`=1 for 4 edges, then 0; `flushD`/`flushE` high throughout.
- Redirect: in RUN, `ex_redirect`=1, `ex_target`=0x0000_0120 → same cycle `flushF`=`flushD`=`flushE`=1, `pc_restore`=0x120.
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 → one cycle of `stallF`=`stallD`=`flushE`=1. With `ex_rd`=0 → no stall.
- Redirect under memory wait:
  - Stimulus: `mem_busy`=1 for 3 cycles, `ex_redirect` with target 0x200 in the first; `ex_target` changes to 0x300 afterwards.
  - Expected: stalls for 3 cycles, then one flush with `pc_restore`=0x200.
- Priority: `ex_redirect` and a load-use hit in the same cycle → flushes only, `stallF`=0.
- Counters (macro on): 2 stall cycles plus 1 redirect → `stall_cnt`=2, `flush_cnt`=1. Reset mid-PEND → both 0, `start`=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and fetch-redirect controller for the 5-stage core.
//
// Resolves the post-reset boot hold, data-memory wait stalls, EX-stage
// branch/jump redirects and load-use hazards. A redirect that arrives while
// memory is busy is captured and applied in the first non-busy cycle.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> saturating stall/flush performance counters are built
//   undefined -> stall_cnt / flush_cnt are tied to zero, no counter flops
//
// Ports:
//   clk, rst                 core clock (rising edge), async active-high reset
//   id_rs1/id_rs2            source registers of the ID instruction
//   id_use_rs1/id_use_rs2    ID instruction really reads rs1 / rs2
//   ex_rd, ex_mem_read       destination and load flag of the EX instruction
//   ex_redirect, ex_target   EX resolved a taken branch/jump and its target
//   mem_busy                 data memory not ready, whole pipe holds
//   start                    hold PC during boot (registered)
//   stallF/stallD/stallE     hold PC, IF/ID, ID/EX
//   flushF                   load pc_restore into the PC
//   flushD/flushE            bubble IF/ID, ID/EX
//   pc_restore               redirect PC (valid when flushF=1)
//   stall_cnt, flush_cnt     performance counters

module hazard_ctrl #(
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            mem_busy,
    output logic            start,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            flushF,
    output logic            flushD,
    output logic            flushE,
    output logic [XLEN-1:0] pc_restore,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        boot_cnt_q, boot_cnt_d;
    logic [XLEN-1:0]   pend_target_q, pend_target_d;
    logic              start_q;
    logic              load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            boot_cnt_q    <= 8'(BOOT_CYCLES - 1);
            pend_target_q <= '0;
            start_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            pend_target_q <= pend_target_d;
            start_q       <= (state_d == BOOT);
        end
    end

    assign start = start_q;

    always_comb begin
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        pend_target_d = pend_target_q;
        stallF        = 1'b0;
        stallD        = 1'b0;
        stallE        = 1'b0;
        flushF        = 1'b0;
        flushD        = 1'b0;
        flushE        = 1'b0;
        pc_restore    = ex_target;

        unique case (state_q)
            BOOT: begin
                flushD = 1'b1;
                flushE = 1'b1;
                // Counter reading 0 means this is the last boot cycle.
                if (boot_cnt_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q - 8'd1;
                end
            end

            RUN: begin
                if (mem_busy) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    if (ex_redirect) begin
                        pend_target_d = ex_target;
                        state_d       = PEND;
                    end
                end else if (ex_redirect) begin
                    flushF = 1'b1;
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (load_use) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
            end

            PEND: begin
                pc_restore = pend_target_q;
                if (mem_busy) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                end else begin
                    // The captured redirect wins; any new EX redirect this cycle is stale.
                    flushF  = 1'b1;
                    flushD  = 1'b1;
                    flushE  = 1'b1;
                    state_d = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q != BOOT) && stallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flushF && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (BOOT_CYCLES=4).

module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_busy;
    logic [31:0] ex_target;
    logic        start, stallF, stallD, stallE, flushF, flushD, flushE;
    logic [31:0] pc_restore, stall_cnt, flush_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    hazard_ctrl #(.BOOT_CYCLES(4), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect),
        .ex_target  (ex_target),
        .mem_busy   (mem_busy),
        .start      (start),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .flushF     (flushF),
        .flushD     (flushD),
        .flushE     (flushE),
        .pc_restore (pc_restore),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic idle();
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        ex_rd       = 5'd0;
        ex_mem_read = 1'b0;
        ex_redirect = 1'b0;
        mem_busy    = 1'b0;
    endtask

    // Checks the six stall/flush controls as one packed vector {sF,sD,sE,fF,fD,fE}.
    task automatic ctl(input string tag, input logic [5:0] exp);
        check(tag, {26'd0, stallF, stallD, stallE, flushF, flushD, flushE}, {26'd0, exp});
    endtask

    // Waits for the boot hold after a reset release to finish (4 edges).
    task automatic boot_wait();
        for (int i = 0; i < 4; i++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        ex_target = 32'h0000_0055;
        #12;
        check("rst_start", {31'd0, start}, 32'd1);
        ctl("rst_ctl", 6'b000011);
        check("rst_pc_restore", pc_restore, 32'h0000_0055);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);

        // Boot hold, with a redirect present that must be ignored.
        @(negedge clk);
        rst = 1'b0;
        ex_redirect = 1'b1;
        ex_target = 32'h0000_0ABC;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            check($sformatf("boot_start_e%0d", k), {31'd0, start}, 32'd1);
            ctl($sformatf("boot_ctl_e%0d", k), 6'b000011);
        end
        @(negedge clk);
        idle(); #1;
        check("boot_done_start", {31'd0, start}, 32'd0);
        ctl("boot_done_ctl", 6'b000000);

        // Redirect in RUN: zero-latency flush.
        @(negedge clk);
        ex_redirect = 1'b1; ex_target = 32'h0000_0120; #1;
        ctl("redir_ctl", 6'b000111);
        check("redir_pc", pc_restore, 32'h0000_0120);

        // Load-use via rs2.
        @(negedge clk);
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; #1;
        ctl("lu_rs2_ctl", 6'b110001);
        @(negedge clk);
        ex_mem_read = 1'b0; #1;
        ctl("lu_cleared_ctl", 6'b000000);

        // ex_rd = 0 never stalls.
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; #1;
        ctl("lu_x0_ctl", 6'b000000);

        // rs1 match but rs1 not used.
        @(negedge clk);
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0; #1;
        ctl("lu_unused_ctl", 6'b000000);
        @(negedge clk);
        id_use_rs1 = 1'b1; #1;
        ctl("lu_rs1_ctl", 6'b110001);

        // Redirect plus load-use: flush only.
        @(negedge clk);
        ex_redirect = 1'b1; ex_target = 32'h0000_0180; #1;
        ctl("prio_ctl", 6'b000111);
        check("prio_pc", pc_restore, 32'h0000_0180);

        // Memory stall alone.
        @(negedge clk);
        idle(); mem_busy = 1'b1; #1;
        ctl("busy_ctl", 6'b111000);

        // Redirect under memory wait.
        @(negedge clk);
        mem_busy = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0200; #1;
        ctl("pend_c1_ctl", 6'b111000);
        @(negedge clk);
        ex_redirect = 1'b0; ex_target = 32'h0000_0300; #1;
        ctl("pend_c2_ctl", 6'b111000);
        @(negedge clk); #1;
        ctl("pend_c3_ctl", 6'b111000);
        @(negedge clk);
        mem_busy = 1'b0; ex_redirect = 1'b1; #1;
        ctl("pend_apply_ctl", 6'b000111);
        check("pend_apply_pc", pc_restore, 32'h0000_0200);
        @(negedge clk);
        idle(); #1;
        ctl("pend_after_ctl", 6'b000000);
        check("pend_after_pc", pc_restore, 32'h0000_0300);

        // Reset in the middle of PEND.
        @(negedge clk);
        mem_busy = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0400;
        @(negedge clk);
        ex_redirect = 1'b0; #1;
        ctl("midpend_pre_ctl", 6'b111000);
        rst = 1'b1; #1;
        check("midpend_start", {31'd0, start}, 32'd1);
        ctl("midpend_rst_ctl", 6'b000011);
        check("midpend_pc", pc_restore, 32'h0000_0400);
        check("midpend_stall_cnt", stall_cnt, 32'd0);
        check("midpend_flush_cnt", flush_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0; idle();
        boot_wait(); #1;
        check("reboot_start", {31'd0, start}, 32'd0);
        ctl("reboot_discard_ctl", 6'b000000);

        // Counters: 2 stall cycles then 1 redirect.
        mem_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_busy = 1'b0; ex_redirect = 1'b1; ex_target = 32'h0000_0010;
        @(negedge clk);
        idle(); #1;
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_stall", stall_cnt, 32'd2);
        check("cnt_flush", flush_cnt, 32'd1);
`else
        check("cnt_stall_off", stall_cnt, 32'd0);
        check("cnt_flush_off", flush_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
